// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: elaboration-time helpers shared by the clock divider files
package clkdiv_pkg;

   // Rounded divisor CLK_FREQ/OUT_FREQ; 0 flags an unusable request
   function automatic int calc_div(input int clk_freq, input int out_freq);
      return (out_freq > 0) ? (clk_freq + out_freq / 2) / out_freq : 0;
   endfunction

   // Phase counter width, never narrower than one bit
   function automatic int calc_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

   // Number of high cycles of the registered output per period
   function automatic int calc_half(input int div);
      return div / 2;
   endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// clkdiv_counter: phase counter wrapping 0..DIV-1, exposing the next count value
module clkdiv_counter
   import clkdiv_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [calc_width(DIV)-1:0] c_next
);

   localparam int W = calc_width(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] c;

   assign c_next = (c == LAST) ? '0 : c + W'(1);

   // Advance the phase on every rising edge, cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) c <= '0;
      else     c <= c_next;
   end

endmodule

// File: rtl/clock_divider_ff.sv
// clock_divider_ff: divides clk by round(CLK_FREQ/OUT_FREQ); CLKDIV_ODD_DUTY50_EN gives 50% duty on odd divisors
module clock_divider_ff
   import clkdiv_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int OUT_FREQ = 48_000
) (
   input  logic clk,
   input  logic rst,
   output logic clk_out,
   output logic tick
);

   localparam int DIV = calc_div(CLK_FREQ, OUT_FREQ);
   localparam int H   = calc_half(DIV);
   localparam int W   = calc_width(DIV);
   localparam logic [W-1:0] RISE = W'(DIV - H);

   generate
      if (CLK_FREQ <= 0 || OUT_FREQ <= 0 || OUT_FREQ > CLK_FREQ || DIV == 0) begin : g_bad
         $fatal(1, "clock_divider_ff: invalid CLK_FREQ=%0d OUT_FREQ=%0d", CLK_FREQ, OUT_FREQ);
         assign clk_out = 1'b0;
         assign tick    = 1'b0;
      end else if (DIV == 1) begin : g_bypass
         // Divide-by-one passes the clock straight through, gated by reset
         assign clk_out = clk & ~rst;
         assign tick    = ~rst;
      end else begin : g_div
         logic [W-1:0] c_next;
         logic         clk_q;
         logic         tick_q;

         clkdiv_counter #(.DIV(DIV)) u_counter (
            .clk    (clk),
            .rst    (rst),
            .c_next (c_next)
         );

         // Output is high for the last H phases; tick marks the rising phase
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               clk_q  <= 1'b0;
               tick_q <= 1'b0;
            end else begin
               clk_q  <= (c_next >= RISE);
               tick_q <= (c_next == RISE);
            end
         end

         assign tick = tick_q;

`ifdef CLKDIV_ODD_DUTY50_EN
         if (DIV % 2 == 1) begin : g_odd
            logic neg_q;

            // Half-cycle delayed copy stretches the high phase by half a clock
            always_ff @(negedge clk or posedge rst) begin
               if (rst) neg_q <= 1'b0;
               else     neg_q <= clk_q;
            end

            assign clk_out = clk_q | neg_q;
         end else begin : g_even
            assign clk_out = clk_q;
         end
`else
         assign clk_out = clk_q;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_clock_divider_ff.sv
// tb_clock_divider_ff: directed checks of divide-by-4, 5, 1 and 1042 instances
`timescale 1ns/1ps
module tb_clock_divider_ff;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic co4, tk4, co5, tk5, co1, tk1, cob, tkb;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   clock_divider_ff #(.CLK_FREQ(8), .OUT_FREQ(2)) u_d4 (
      .clk(clk), .rst(rst), .clk_out(co4), .tick(tk4));
   clock_divider_ff #(.CLK_FREQ(10), .OUT_FREQ(2)) u_d5 (
      .clk(clk), .rst(rst), .clk_out(co5), .tick(tk5));
   clock_divider_ff #(.CLK_FREQ(48_000), .OUT_FREQ(48_000)) u_d1 (
      .clk(clk), .rst(rst), .clk_out(co1), .tick(tk1));
   clock_divider_ff u_db (
      .clk(clk), .rst(rst), .clk_out(cob), .tick(tkb));

   always #5 clk = ~clk;

   // Rising edges since the last reset release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string tag, input int idx, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
      end
   endtask

   initial begin
      int e4c[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
      int e4t[8] = '{0, 1, 0, 0, 0, 1, 0, 0};
      int e5t[10] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
`ifdef CLKDIV_ODD_DUTY50_EN
      int e5c[10] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
      int duty5 = 10;
`else
      int e5c[10] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
      int duty5 = 8;
`endif
      int hi;
      int n;
      int found;

      repeat (3) @(posedge clk);
      #1;
      check("rst_co4", 0, int'(co4), 0);
      check("rst_tk4", 0, int'(tk4), 0);
      check("rst_co5", 0, int'(co5), 0);
      check("rst_tk5", 0, int'(tk5), 0);
      check("rst_co1", 0, int'(co1), 0);
      check("rst_tk1", 0, int'(tk1), 0);
      check("rst_cob", 0, int'(cob), 0);
      check("rst_tkb", 0, int'(tkb), 0);

      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (i < 8) begin
            check("d4_co", i + 1, int'(co4), e4c[i]);
            check("d4_tk", i + 1, int'(tk4), e4t[i]);
         end
         check("d5_co", i + 1, int'(co5), e5c[i]);
         check("d5_tk", i + 1, int'(tk5), e5t[i]);
         check("d1_co_hi", i + 1, int'(co1), 1);
         check("d1_tk_hi", i + 1, int'(tk1), 1);
      end
      @(negedge clk);
      #1;
      check("d1_co_lo", 0, int'(co1), 0);
      check("d1_tk_lo", 0, int'(tk1), 1);

      hi = 0;
      repeat (10) begin
         @(posedge clk);
         #1 hi += int'(co5);
         @(negedge clk);
         #1 hi += int'(co5);
      end
      check("d5_high_halves", 0, hi, duty5);

      n = 0;
      found = 0;
      while (n < 2000 && found == 0) begin
         @(posedge clk);
         #1;
         n++;
         if (tkb) found = 1;
      end
      check("db_first_rise", 0, cyc, 521);
      check("db_first_co", 0, int'(cob), 1);

      for (int p = 0; p < 10; p++) begin
         n = 0;
         hi = 0;
         do begin
            @(posedge clk);
            #1;
            n++;
            hi += int'(cob);
         end while (!tkb && n < 2000);
         check("db_period", p, n, 1042);
         check("db_high", p, hi, 521);
      end

      n = 0;
      found = 0;
      while (n < 20 && found == 0) begin
         @(posedge clk);
         #1;
         n++;
         if (co4) found = 1;
      end
      check("d4_found_high", 0, found, 1);
      #1 rst = 1'b1;
      #1;
      check("midrst_co4", 0, int'(co4), 0);
      check("midrst_tk4", 0, int'(tk4), 0);
      check("midrst_co5", 0, int'(co5), 0);
      check("midrst_co1", 0, int'(co1), 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      check("rerel_co4", 1, int'(co4), 0);
      check("rerel_tk4", 1, int'(tk4), 0);
      @(posedge clk);
      #1;
      check("rerel_co4", 2, int'(co4), 1);
      check("rerel_tk4", 2, int'(tk4), 1);
      @(posedge clk);
      #1;
      check("rerel_tk4", 3, int'(tk4), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
